// File: rtl/bakraid_pal_arb.sv
// Palette RAM arbiter: video lookups, CPU port and clear engine share one
// pipelined single-port RAM. One issue per cycle, results return two edges later.
module bakraid_pal_arb #(
    parameter int              AW      = 11,
    parameter int              DW      = 16,
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input  logic          CLK96,
    input  logic          RESET96_N,
    input  logic          PIXEL_CEN,
    input  logic [AW-1:0] PIXEL,
    output logic [DW-1:0] VID_DATA,
    output logic          VID_VALID,
    input  logic          CPU_REQ,
    input  logic          CPU_WE,
    input  logic [AW-1:0] CPU_ADDR,
    input  logic [DW-1:0] CPU_DIN,
    output logic [DW-1:0] CPU_DOUT,
    output logic          CPU_ACK,
    input  logic          CLR_START,
    output logic          CLR_BUSY,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_DIN,
    output logic          RAM_WE,
    input  logic [DW-1:0] RAM_DOUT
);

    // Both CPU tags share bit 1 so the completion check is a single bit.
    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_VID  = 2'd1;
    localparam logic [1:0] TAG_CRD  = 2'd2;
    localparam logic [1:0] TAG_CWR  = 2'd3;

    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_din_q,  ram_din_d;
    logic            ram_we_q,   ram_we_d;
    logic [2:1][1:0] tag_q;
    logic [1:0]      tag_d;
    logic            cpu_infl_q, cpu_infl_d;
    logic            clr_busy_q, clr_busy_d;
    logic [AW-1:0]   clr_cnt_q,  clr_cnt_d;
    logic [DW-1:0]   vid_data_q, vid_data_d;
    logic            vid_vld_q,  vid_vld_d;
    logic [DW-1:0]   cpu_dout_q, cpu_dout_d;
    logic            cpu_ack_q,  cpu_ack_d;

    logic sel_cpu, sel_clr;

    assign sel_cpu = !PIXEL_CEN && CPU_REQ && !cpu_infl_q;
    assign sel_clr = !PIXEL_CEN && !sel_cpu && clr_busy_q;

    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        tag_d      = TAG_NONE;
        if (PIXEL_CEN) begin
            ram_addr_d = PIXEL;
            tag_d      = TAG_VID;
        end else if (sel_cpu) begin
            ram_addr_d = CPU_ADDR;
            ram_din_d  = CPU_DIN;
            ram_we_d   = CPU_WE;
            tag_d      = CPU_WE ? TAG_CWR : TAG_CRD;
        end else if (sel_clr) begin
            ram_addr_d = clr_cnt_q;
            ram_din_d  = CLR_VAL;
            ram_we_d   = 1'b1;
        end
    end

    // A start pulse always wins, even against the final clear issue.
    always_comb begin
        clr_busy_d = clr_busy_q;
        clr_cnt_d  = clr_cnt_q;
        if (CLR_START) begin
            clr_busy_d = 1'b1;
            clr_cnt_d  = '0;
        end else if (sel_clr) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) clr_busy_d = 1'b0;
        end
    end

    always_comb begin
        vid_vld_d  = (tag_q[2] == TAG_VID);
        vid_data_d = vid_vld_d ? RAM_DOUT : vid_data_q;
        cpu_ack_d  = tag_q[2][1];
        cpu_dout_d = (tag_q[2] == TAG_CRD) ? RAM_DOUT : cpu_dout_q;
        cpu_infl_d = cpu_infl_q;
        if (cpu_ack_d) cpu_infl_d = 1'b0;
        if (sel_cpu)   cpu_infl_d = 1'b1;
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            tag_q      <= '0;
            cpu_infl_q <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_cnt_q  <= '0;
            vid_data_q <= '0;
            vid_vld_q  <= 1'b0;
            cpu_dout_q <= '0;
            cpu_ack_q  <= 1'b0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            tag_q      <= {tag_q[1], tag_d};
            cpu_infl_q <= cpu_infl_d;
            clr_busy_q <= clr_busy_d;
            clr_cnt_q  <= clr_cnt_d;
            vid_data_q <= vid_data_d;
            vid_vld_q  <= vid_vld_d;
            cpu_dout_q <= cpu_dout_d;
            cpu_ack_q  <= cpu_ack_d;
        end
    end

    assign RAM_ADDR  = ram_addr_q;
    assign RAM_DIN   = ram_din_q;
    assign RAM_WE    = ram_we_q;
    assign VID_DATA  = vid_data_q;
    assign VID_VALID = vid_vld_q;
    assign CPU_DOUT  = cpu_dout_q;
    assign CPU_ACK   = cpu_ack_q;
    assign CLR_BUSY  = clr_busy_q;

endmodule

// File: doc/bakraid_pal_arb.md
Name: bakraid_pal_arb

Overview:
- Arbiter and sequencer for the single-port 2048x16 palette RAM shared by the video pixel lookup, the CPU palette port and a palette-clear engine.
- Runs in the 96 MHz video domain. Feeds registered palette words to the colour-expansion stage.
- Video has fixed top priority. The RAM is pipelined, so one access issues per cycle and up to two are in flight.

Parameters:
- AW, 11, palette address width (2^AW entries)
- DW, 16, palette word width
- CLR_VAL, 16'h0000, value written by the clear engine

Ports:
- CLK96  in  1  clock
- RESET96_N  in  1  asynchronous active-low reset
- PIXEL_CEN  in  1  pixel clock enable; requests a video lookup this cycle
- PIXEL  in  AW  video palette index, sampled with PIXEL_CEN
- VID_DATA  out  DW  palette word for the last video lookup, held between lookups
- VID_VALID  out  1  one-cycle pulse when VID_DATA updates
- CPU_REQ  in  1  CPU access request, level
- CPU_WE  in  1  1=write, 0=read; sampled at issue
- CPU_ADDR  in  AW  CPU address
- CPU_DIN  in  DW  CPU write data
- CPU_DOUT  out  DW  CPU read data, held until the next CPU read
- CPU_ACK  out  1  one-cycle completion pulse
- CLR_START  in  1  pulse; starts or restarts a full-palette clear
- CLR_BUSY  out  1  high while the clear engine is active
- RAM_ADDR  out  AW  registered RAM address
- RAM_DIN  out  DW  registered RAM write data
- RAM_WE  out  1  registered RAM write strobe
- RAM_DOUT  in  DW  RAM read data, valid 1 cycle after RAM_ADDR is registered

Behaviour:
- Reset: on RESET96_N low, asynchronously force every output to 0 (VID_DATA, VID_VALID, CPU_DOUT, CPU_ACK, CLR_BUSY, RAM_ADDR, RAM_DIN, RAM_WE). Also clear the pipeline tags, the CPU in-flight flag and the clear counter.
- Reset mid-operation: the in-flight access is discarded and produces no ACK or VALID. An active clear is aborted.

Issue arbitration, evaluated each cycle (cycle t), result registered at the t+1 edge:
- If PIXEL_CEN: video read. RAM_ADDR<=PIXEL, RAM_WE<=0.
- Else if CPU_REQ && !cpu_inflight: CPU access. RAM_ADDR<=CPU_ADDR. RAM_WE<=CPU_WE. RAM_DIN<=CPU_DIN. Set cpu_inflight.
- Else if CLR_BUSY: clear write. RAM_ADDR<=clr_cnt, RAM_DIN<=CLR_VAL, RAM_WE<=1. Increment clr_cnt.
- Else idle: RAM_WE<=0, RAM_ADDR holds.
- The RAM_WE pulse lasts exactly one cycle per write.

Pipeline:
- A 2-stage tag shift register records NONE/VID/CPU_RD/CPU_WR for each issued access.
- Stage-2 tag VID: VID_DATA<=RAM_DOUT, and VID_VALID pulses. VID_DATA is available 3 edges after the PIXEL_CEN cycle.
- Stage-2 tag CPU_RD: CPU_DOUT<=RAM_DOUT, CPU_ACK pulses, cpu_inflight clears.
- Stage-2 tag CPU_WR: CPU_ACK pulses, cpu_inflight clears.
- CPU_REQ still high in the cycle after CPU_ACK counts as a new request.

CPU starvation:
- PIXEL_CEN high every cycle starves the CPU. This is legal; the CPU waits.
- The design relies on PIXEL_CEN from the 96 MHz divider having a period of at least 2 cycles.

Clear engine:
- CLR_START sets CLR_BUSY and clr_cnt<=0, including when already busy (restart).
- CLR_BUSY falls on the edge that issues the write to address 2^AW-1. clr_cnt wraps to 0.
- CLR_START in the same cycle as the final clear issue takes precedence: the clear restarts.
- A CPU write during a clear is allowed; a later clear write may overwrite it.

Simultaneous events:
- PIXEL_CEN with CPU_REQ: video issues, CPU waits 1 cycle.
- VID and CPU completions never collide, because issue is one per cycle.

Widths: addresses are unsigned, and clr_cnt is AW bits wrapping modulo 2^AW. No arithmetic beyond the increment.

Test Plan:
- Reset release, idle: all outputs 0. Pulse PIXEL_CEN with PIXEL=11'h123 and RAM model [0x123]=16'h7FFF -> RAM_ADDR=0x123 after edge 1; VID_DATA=16'h7FFF with a VID_VALID pulse after edge 3.
- CPU write: CPU_REQ=1, WE=1, ADDR=0x010, DIN=16'h1234 -> one-cycle RAM_WE at 0x010, CPU_ACK 2 cycles after issue. A following CPU read of 0x010 -> CPU_DOUT=16'h1234 with CPU_ACK.
- Contention: CPU_REQ and PIXEL_CEN asserted in the same cycle -> video issues first, CPU issues the next cycle, VID_VALID precedes CPU_ACK by 1 cycle, both data values correct.
- Clear: preload all entries with 16'hFFFF, pulse CLR_START, PIXEL_CEN every 4th cycle -> all 2048 entries read 0, CLR_BUSY high for exactly 2048 plus the number of video-stolen cycles, and no video result is lost.
- Restart and abort: CLR_START again at clr_cnt=0x200 -> the counter restarts at 0. Assert RESET96_N low with a CPU read in flight -> no CPU_ACK, CLR_BUSY=0, all outputs 0.
- Starvation: PIXEL_CEN every other cycle with CPU_REQ held high -> the CPU completes in the gap cycles, and every PIXEL_CEN produces exactly one VID_VALID.
